// File: rtl/lockpick_session_arbiter.sv
// Purpose : shares one lockpick_game between N_PLAYERS requesters, round-robin, one full session per grant.
// Latency : grant registered one edge after req seen in IDLE; key/result bytes pass through combinationally.
// Backpressure: only the owner sees in_ready; result bytes cannot be stalled (forwarded same cycle).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req/in_valid/in_data/in_ready   per-player session request and key byte stream
//   gnt/gnt_id/busy                 current owner (one-hot and index)
//   game_*                          drive/observe the shared lockpick_game
//   out_valid/out_data/out_id       result bytes tagged with the owner id
//   done/done_id/done_result        one-cycle session-end pulse (10 win, 11 lock-out, 00 aborted)
module lockpick_session_arbiter #(
    parameter int N_PLAYERS = 4,
    parameter int ID_W      = 2,
    parameter int TIMEOUT   = 1024,
    parameter int OUT_WDOG  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PLAYERS-1:0]   req,
    input  logic [N_PLAYERS-1:0]   in_valid,
    input  logic [8*N_PLAYERS-1:0] in_data,
    output logic [N_PLAYERS-1:0]   in_ready,
    output logic [N_PLAYERS-1:0]   gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   busy,
    output logic                   game_rst_n,
    output logic                   game_start,
    output logic                   game_input_enable,
    output logic [7:0]             game_input_data,
    input  logic                   game_output_valid,
    input  logic [7:0]             game_output_data,
    input  logic [1:0]             game_status,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [1:0]             done_result
);

    // One timer serves the LOAD idle timeout, the WAIT_OUT watchdog and the ABORT reset length.
    localparam int TMR_MAX = (TIMEOUT > OUT_WDOG) ? TIMEOUT : OUT_WDOG;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_WAIT_OUT,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t               state_q, state_d;
    logic [N_PLAYERS-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 busy_q, busy_d;
    logic [5:0]           bcnt_q, bcnt_d;
    logic [4:0]           ocnt_q, ocnt_d;
    logic [7:0]           attempts_q, attempts_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 game_rst_n_q, game_rst_n_d;
    logic                 done_q, done_d;
    logic [ID_W-1:0]      done_id_q, done_id_d;
    logic [1:0]           done_result_q, done_result_d;

    logic                 arb_found;
    logic [ID_W-1:0]      arb_id;
    logic                 sel_vld;
    logic [7:0]           sel_dat;
    logic                 owner_req;
    logic                 accept;

    // Round-robin: first pass looks above the pointer, second pass wraps to 0..ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!arb_found && req[i] && (ID_W'(i) > ptr_q)) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!arb_found && req[i] && (ID_W'(i) <= ptr_q)) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(i);
            end
        end
    end

    // Owner's byte lane.
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = 8'h00;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (gnt_id_q == ID_W'(i)) begin
                sel_vld = in_valid[i];
                sel_dat = in_data[8*i +: 8];
            end
        end
    end

    assign owner_req = |(req & gnt_q);

    assign in_ready          = (state_q == S_LOAD) ? gnt_q : '0;
    assign game_input_enable = (state_q == S_LOAD) && sel_vld && game_rst_n_q;
    assign game_input_data   = (state_q == S_LOAD) ? sel_dat : 8'h00;
    assign game_start        = (state_q == S_START) && game_rst_n_q;
    assign accept            = game_input_enable;

    assign out_valid = game_output_valid && ((state_q == S_WAIT_OUT) || (state_q == S_DRAIN));
    assign out_data  = out_valid ? game_output_data : 8'h00;
    assign out_id    = out_valid ? gnt_id_q : '0;

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign game_rst_n  = game_rst_n_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign done_result = done_result_q;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        ptr_d         = ptr_q;
        busy_d        = busy_q;
        bcnt_d        = bcnt_q;
        ocnt_d        = ocnt_q;
        attempts_d    = attempts_q;
        tmr_d         = tmr_q;
        done_d        = 1'b0;
        done_id_d     = '0;
        done_result_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d    = {{(N_PLAYERS-1){1'b0}}, 1'b1} << arb_id;
                    gnt_id_d = arb_id;
                    ptr_d    = arb_id;
                    busy_d   = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                bcnt_d     = '0;
                ocnt_d     = '0;
                attempts_d = '0;
                tmr_d      = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                // An abandoned session wins over a byte arriving in the same cycle.
                if (!owner_req) begin
                    tmr_d   = '0;
                    state_d = S_ABORT;
                end else if (accept) begin
                    bcnt_d = bcnt_q + 6'd1;
                    tmr_d  = '0;
                    if (bcnt_q == 6'd63) begin
                        state_d = S_WAIT_OUT;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    tmr_d   = '0;
                    state_d = S_ABORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_OUT: begin
                if (!owner_req) begin
                    tmr_d   = '0;
                    state_d = S_ABORT;
                end else if (game_output_valid) begin
                    ocnt_d  = 5'd1;
                    state_d = S_DRAIN;
                end else if (tmr_q == TMR_W'(OUT_WDOG - 1)) begin
                    tmr_d   = '0;
                    state_d = S_ABORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                // req is deliberately not looked at here: the burst always completes,
                // and a dropped req is caught in LOAD if the game re-arms.
                if (game_output_valid) begin
                    if (ocnt_q == 5'd31) begin
                        ocnt_d = '0;
                        case (game_status)
                            2'b01: begin
                                attempts_d = attempts_q + 8'd1;
                                bcnt_d     = '0;
                                tmr_d      = '0;
                                state_d    = S_LOAD;
                            end
                            2'b10, 2'b11: begin
                                done_d        = 1'b1;
                                done_id_d     = gnt_id_q;
                                done_result_d = game_status;
                                gnt_d         = '0;
                                gnt_id_d      = '0;
                                busy_d        = 1'b0;
                                state_d       = S_IDLE;
                            end
                            default: begin
                                tmr_d   = '0;
                                state_d = S_ABORT;
                            end
                        endcase
                    end else begin
                        ocnt_d = ocnt_q + 5'd1;
                    end
                end
            end
            S_ABORT: begin
                // Game reset is held for this cycle and the next one.
                if (tmr_q == TMR_W'(1)) begin
                    done_d        = 1'b1;
                    done_id_d     = gnt_id_q;
                    done_result_d = 2'b00;
                    gnt_d         = '0;
                    gnt_id_d      = '0;
                    busy_d        = 1'b0;
                    tmr_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so the game reset is glitch-free and lines up with the ABORT cycles.
        game_rst_n_d = (state_d != S_ABORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            ptr_q         <= ID_W'(N_PLAYERS - 1);
            busy_q        <= 1'b0;
            bcnt_q        <= '0;
            ocnt_q        <= '0;
            attempts_q    <= '0;
            tmr_q         <= '0;
            game_rst_n_q  <= 1'b0;
            done_q        <= 1'b0;
            done_id_q     <= '0;
            done_result_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            bcnt_q        <= bcnt_d;
            ocnt_q        <= ocnt_d;
            attempts_q    <= attempts_d;
            tmr_q         <= tmr_d;
            game_rst_n_q  <= game_rst_n_d;
            done_q        <= done_d;
            done_id_q     <= done_id_d;
            done_result_q <= done_result_d;
        end
    end

endmodule
